// File: rtl/pong_draw_pkg.sv
// Shared constants for the pong draw path: screen geometry, colours,
// requester indices and the plot arbiter state encoding.
package pong_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_LPAD  = 1;
  localparam int REQ_RPAD  = 2;
  localparam int REQ_BALL  = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ARB   = S_ARB,
    BURST = S_BURST
  } state_t;

  // True when a pixel lands inside the visible framebuffer.
  function automatic logic on_screen(input int xv, input int yv);
    return (xv < SCREEN_W) && (yv < SCREEN_H);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr+1,
// wrapping modulo N, returned as one-hot plus binary index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int j;
    logic [PW-1:0] jj;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter plot port among N_REQ burst requesters with capped
// round-robin grants, and generates frame_tick. Optional clipping: PLOT_CLIP_EN.
module vga_plot_arbiter
  import pong_draw_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int C_W       = 3,
  parameter int MAX_BURST = 256,
  parameter int FRAME_DIV = 833333
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     last,
  input  logic [N_REQ*X_W-1:0] px,
  input  logic [N_REQ*Y_W-1:0] py,
  input  logic [N_REQ*C_W-1:0] pcol,
  output logic [N_REQ-1:0]     grant,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [C_W-1:0]       colour,
  output logic                 plot,
  output logic                 frame_tick,
  output logic                 busy,
`ifdef PLOT_CLIP_EN
  output logic [15:0]          clip_count,
`endif
  output state_t               state
);

  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int FW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_BURST - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAME_DIV - 1);

  logic [PW-1:0]    ptr;
  logic [CNT_W-1:0] count;
  logic [FW-1:0]    frame_cnt;

  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [C_W-1:0]   sel_col;
  logic             sel_last;
  logic             consume;
  logic             burst_end;
  logic             pix_ok;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // ptr always holds the current grant holder while in BURST.
  always_comb begin
    sel_x     = px[int'(ptr)*X_W +: X_W];
    sel_y     = py[int'(ptr)*Y_W +: Y_W];
    sel_col   = pcol[int'(ptr)*C_W +: C_W];
    sel_last  = last[ptr];
    consume   = |(grant & req);
    burst_end = sel_last || (count == CNT_LAST);
  end

`ifdef PLOT_CLIP_EN
  assign pix_ok = on_screen(int'(sel_x), int'(sel_y));
`else
  assign pix_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      grant  <= '0;
      ptr    <= PW'(N_REQ - 1);
      count  <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) state <= ARB;
        end
        ARB: begin
          if (pick_any) begin
            grant <= pick_onehot;
            ptr   <= pick_idx;
            count <= '0;
            state <= BURST;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        BURST: begin
          if (consume) begin
            x      <= sel_x;
            y      <= sel_y;
            colour <= sel_col;
            plot   <= pix_ok;
            count  <= count + 1'b1;
            if (burst_end) begin
              grant <= '0;
              state <= ARB;
            end
          end else begin
            // Holder withdrew without last: release and re-arbitrate.
            grant <= '0;
            state <= ARB;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else if (frame_cnt == FRAME_LAST) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b1;
    end else begin
      frame_cnt  <= frame_cnt + 1'b1;
      frame_tick <= 1'b0;
    end
  end

`ifdef PLOT_CLIP_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clip_count <= '0;
    end else if (consume && !pix_ok && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: per-requester pixel queues act as the
// draw clients; each scenario task checks grant order, burst sizes and pixels.
module tb_vga_plot_arbiter;
  import pong_draw_pkg::*;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int MB = 4;
  localparam int FD = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic [N-1:0]    req, last;
  logic [N*XW-1:0] px;
  logic [N*YW-1:0] py;
  logic [N*CW-1:0] pcol;
  logic [N-1:0]    grant;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic            plot, frame_tick, busy;
`ifdef PLOT_CLIP_EN
  logic [15:0]     clip_count;
`endif
  state_t          state;

  vga_plot_arbiter #(
    .N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .MAX_BURST(MB), .FRAME_DIV(FD)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .last(last),
    .px(px), .py(py), .pcol(pcol), .grant(grant),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .frame_tick(frame_tick), .busy(busy),
`ifdef PLOT_CLIP_EN
    .clip_count(clip_count),
`endif
    .state(state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Requester pixel queues: {last, x, y, colour}
  logic [20:0] pq [N][$];
  logic [19:0] exp_q[$];
  int gorder[$];
  int blen[$];
  int cur_len, hi_cnt, first_hi, last_hi, tick_cnt, step_no;
  logic [15:0] plot_hist;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic push_px(input int r, input logic lst, input logic [8:0] xx,
                         input logic [7:0] yy, input logic [2:0] cc);
    pq[r].push_back({lst, xx, yy, cc});
  endtask

  task automatic refresh();
    logic [20:0] hd;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        hd = pq[i][0];
        req[i]               = 1'b1;
        last[i]              = hd[20];
        px[i*XW +: XW]       = hd[19:11];
        py[i*YW +: YW]       = hd[10:3];
        pcol[i*CW +: CW]     = hd[2:0];
      end else begin
        req[i]               = 1'b0;
        last[i]              = 1'b0;
        px[i*XW +: XW]       = '0;
        py[i*YW +: YW]       = '0;
        pcol[i*CW +: CW]     = '0;
      end
    end
  endtask

  task automatic clear_logs();
    gorder.delete();
    blen.delete();
    cur_len  = 0;
    hi_cnt   = 0;
    first_hi = -1;
    last_hi  = -1;
    tick_cnt = 0;
    step_no  = 0;
    plot_hist = '0;
  endtask

  // One clock: model consumption, advance, then check plot/pixel/tick.
  task automatic step();
    logic [N-1:0] cons, prev_g;
    logic [20:0]  hd;
    logic [19:0]  e;
    logic         exp_plot, exp_tick;
    int           ci;
    cons = resetn ? (grant & req) : '0;
    ci = -1;
    exp_plot = 1'b0;
    hd = '0;
    for (int i = 0; i < N; i++) if (cons[i]) ci = i;
    if (ci >= 0) begin
      hd = pq[ci][0];
      exp_plot = 1'b1;
`ifdef PLOT_CLIP_EN
      if (int'(hd[19:11]) >= SCREEN_W || int'(hd[10:3]) >= SCREEN_H) exp_plot = 1'b0;
`endif
      if (exp_plot) exp_q.push_back(hd[19:0]);
      cur_len++;
    end
    prev_g = grant;
    @(posedge clk);
    #1;
    if (ci >= 0) hd = pq[ci].pop_front();
    if (resetn) cyc++; else cyc = 0;
    step_no++;
    n_vec++;
    if (plot !== exp_plot) begin
      n_err++;
      $display("FAIL plot @cyc%0d: got %b want %b", cyc, plot, exp_plot);
    end
    if (exp_plot) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({x, y, colour} !== e) begin
        n_err++;
        $display("FAIL pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                 x, y, colour, e[19:11], e[10:3], e[2:0]);
      end
    end
    exp_tick = (cyc != 0) && (cyc % FD == 0);
    n_vec++;
    if (frame_tick !== exp_tick) begin
      n_err++;
      $display("FAIL frame_tick @cyc%0d: got %b want %b", cyc, frame_tick, exp_tick);
    end
    n_vec++;
    if (!$onehot0(grant)) begin
      n_err++;
      $display("FAIL grant_onehot: got %b want at most one bit", grant);
    end
    if (prev_g === '0 && grant !== '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
    end
    if (prev_g !== '0 && grant === '0) begin
      blen.push_back(cur_len);
      cur_len = 0;
    end
    if (plot === 1'b1) begin
      hi_cnt++;
      if (first_hi < 0) first_hi = step_no;
      last_hi = step_no;
    end
    if (frame_tick === 1'b1) tick_cnt++;
    plot_hist = {plot_hist[14:0], plot};
    refresh();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    refresh();
    step();
    step();
    resetn = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_idle(input int max_cycles, input string name);
    int k = 0;
    while (k < max_cycles) begin
      step();
      k++;
      if (pending() == 0 && busy === 1'b0) break;
    end
    n_vec++;
    if (!(pending() == 0 && busy === 1'b0)) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d pixels pending busy=%b want 0 and idle", name, pending(), busy);
    end
  endtask

  task automatic check_list(input string name, input int got[$], input int want[$]);
    n_vec++;
    if (got.size() != want.size()) begin
      n_err++;
      $display("FAIL %s_len: got %0d entries want %0d", name, got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        n_vec++;
        if (got[i] != want[i]) begin
          n_err++;
          $display("FAIL %s[%0d]: got %0d want %0d", name, i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req = '0; last = '0; px = '0; py = '0; pcol = '0;
    clear_logs();
    step();
    step();
    n_vec++;
    if ({grant, x, y, colour, plot, frame_tick, busy} !== '0 || state !== IDLE) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b x=%0d y=%0d c=%0d plot=%b tick=%b busy=%b want all 0",
               grant, x, y, colour, plot, frame_tick, busy);
    end
    resetn = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_burst();
    clear_logs();
    push_px(REQ_CLEAR, 1'b0, 9'd10, 8'd20, 3'b101);
    push_px(REQ_CLEAR, 1'b0, 9'd11, 8'd21, 3'b110);
    push_px(REQ_CLEAR, 1'b1, 9'd12, 8'd22, WHITE);
    refresh();
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 1) begin
        n_vec++;
        if (grant !== 4'b0001) begin
          n_err++;
          $display("FAIL single_grant: got %b want 0001", grant);
        end
      end
    end
    n_vec++;
    if (plot_hist[6:0] !== 7'b0011100) begin
      n_err++;
      $display("FAIL single_plot_timing: got %b want 0011100", plot_hist[6:0]);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got %b want 0", busy);
    end
    check_list("single_order", gorder, '{0});
    check_list("single_len", blen, '{3});
  endtask

  task automatic test_round_robin();
    do_reset();
    push_px(0, 1'b0, 9'd1, 8'd1, 3'd1);
    push_px(0, 1'b1, 9'd2, 8'd2, 3'd1);
    push_px(0, 1'b0, 9'd3, 8'd3, 3'd2);
    push_px(0, 1'b1, 9'd4, 8'd4, 3'd2);
    for (int r = 1; r < N; r++) begin
      push_px(r, 1'b0, 9'(40 * r), 8'(10 * r), 3'(r));
      push_px(r, 1'b1, 9'(40 * r + 1), 8'(10 * r + 1), 3'(r + 4));
    end
    refresh();
    run_until_idle(80, "rr");
    check_list("rr_order", gorder, '{0, 1, 2, 3, 0});
    check_list("rr_len", blen, '{2, 2, 2, 2, 2});
    n_vec++;
    if (hi_cnt != 10 || (last_hi - first_hi + 1) != 14) begin
      n_err++;
      $display("FAIL rr_gaps: got %0d plots over %0d cycles want 10 over 14", hi_cnt, last_hi - first_hi + 1);
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    for (int k = 0; k < 10; k++)
      push_px(REQ_RPAD, k == 9, 9'(100 + k), 8'(50 + k), 3'(k));
    push_px(REQ_BALL, 1'b0, 9'd150, 8'd110, WHITE);
    push_px(REQ_BALL, 1'b1, 9'd151, 8'd111, WHITE);
    refresh();
    run_until_idle(80, "cap");
    check_list("cap_order", gorder, '{2, 3, 2, 2});
    check_list("cap_len", blen, '{4, 2, 4, 2});
    n_vec++;
    if (hi_cnt != 12) begin
      n_err++;
      $display("FAIL cap_plots: got %0d want 12", hi_cnt);
    end
  endtask

  task automatic test_drop_req();
    clear_logs();
    push_px(REQ_LPAD, 1'b0, 9'd5, 8'd60, 3'd3);
    push_px(REQ_LPAD, 1'b0, 9'd5, 8'd61, 3'd3);
    push_px(REQ_RPAD, 1'b1, 9'd154, 8'd60, 3'd4);
    refresh();
    run_until_idle(40, "drop");
    check_list("drop_order", gorder, '{1, 2});
    check_list("drop_len", blen, '{2, 1});
    n_vec++;
    if (hi_cnt != 3) begin
      n_err++;
      $display("FAIL drop_plots: got %0d want 3", hi_cnt);
    end
  endtask

  task automatic test_frame_tick();
    do_reset();
    for (int k = 0; k < 12; k++)
      push_px(REQ_CLEAR, k == 11, 9'(k), 8'(k + 1), BLACK);
    refresh();
    for (int k = 0; k < 25; k++) begin
      step();
      if (k == 9) begin
        n_vec++;
        if (frame_tick !== 1'b1 || plot !== 1'b1) begin
          n_err++;
          $display("FAIL tick_in_burst: got tick=%b plot=%b want 1 1", frame_tick, plot);
        end
      end
    end
    n_vec++;
    if (tick_cnt != 2) begin
      n_err++;
      $display("FAIL tick_count: got %0d want 2", tick_cnt);
    end
    check_list("tick_len", blen, '{4, 4, 4});
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++)
      push_px(REQ_LPAD, k == 3, 9'(70 + k), 8'(30 + k), 3'd6);
    refresh();
    for (int k = 0; k < 4; k++) step();
    n_vec++;
    if (plot !== 1'b1 || grant !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_pre: got plot=%b grant=%b want 1 0010", plot, grant);
    end
    resetn = 1'b0;
    step();
    n_vec++;
    if ({grant, x, y, colour, plot, frame_tick, busy} !== '0 || state !== IDLE) begin
      n_err++;
      $display("FAIL midrst_outputs: got grant=%b x=%0d y=%0d c=%0d plot=%b tick=%b busy=%b want all 0",
               grant, x, y, colour, plot, frame_tick, busy);
    end
    do_reset();
`ifdef PLOT_CLIP_EN
    push_px(REQ_BALL, 1'b1, 9'd160, 8'd5, WHITE);
    push_px(REQ_BALL, 1'b1, 9'd159, 8'd119, WHITE);
    refresh();
    run_until_idle(40, "clip");
    n_vec++;
    if (clip_count !== 16'd1) begin
      n_err++;
      $display("FAIL clip_count: got %0d want 1", clip_count);
    end
    n_vec++;
    if (hi_cnt != 1) begin
      n_err++;
      $display("FAIL clip_plots: got %0d want 1", hi_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_burst_cap();
    test_drop_req();
    test_frame_tick();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
